// File: rtl/instr_enable_ctl_if.sv
// instr_enable_ctl_if
//   Bundles the host configuration port, the retired-opcode trace and the
//   checker status outputs of instr_enable_ctl.
//   master : testbench host / trace source (drives cfg_* and opcode inputs)
//   slave  : instr_enable_ctl
//   cfg_start/cfg_done : one-cycle pulses (clear+load, arm)
//   cfg_valid/cfg_ready: byte write handshake on cfg_addr/cfg_data
//   valid_op, opcode_1, opcode_2 : one retired opcode per cycle
//   armed, viol_valid, viol_opcode, err_count, endsim : checker status
interface instr_enable_ctl_if;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_done;
    logic        valid_op;
    logic [7:0]  opcode_1;
    logic [7:0]  opcode_2;
    logic        armed;
    logic        viol_valid;
    logic [15:0] viol_opcode;
    logic [7:0]  err_count;
    logic        endsim;

    modport master (
        output cfg_start, cfg_valid, cfg_addr, cfg_data, cfg_done,
               valid_op, opcode_1, opcode_2,
        input  cfg_ready, armed, viol_valid, viol_opcode, err_count, endsim
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_addr, cfg_data, cfg_done,
               valid_op, opcode_1, opcode_2,
        output cfg_ready, armed, viol_valid, viol_opcode, err_count, endsim
    );
endinterface

// File: rtl/instr_enable_ctl.sv
// instr_enable_ctl
//   Owns the primary and 0xff-extended opcode enable bitmaps used for cosim
//   instruction checking. The host loads both tables byte by byte, arms the
//   checker, and every retired opcode is then looked up; a cleared bit is a
//   violation. Once enough violations are seen, a drain window lets trace and
//   log output flush before the sticky endsim request is raised.
//   Parameters:
//     DRAIN_CYCLES : cycles spent in DRAIN before endsim (0..255)
//     MAX_ERRORS   : violation count that starts shutdown (1..255)
//   Ports:
//     clk     : sole clock, rising edge
//     reset_l : asynchronous active-low reset
//     bus     : instr_enable_ctl_if.slave (config port, trace, status)
module instr_enable_ctl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MAX_ERRORS   = 1
) (
    input logic               clk,
    input logic               reset_l,
    instr_enable_ctl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0] DRAIN_LEN = 8'(DRAIN_CYCLES);
    localparam logic [7:0] ERR_LIMIT = 8'(MAX_ERRORS);

    state_t       state_q, state_d;
    logic [255:0] inst_en_q, inst_en_d;
    logic [255:0] ext_en_q, ext_en_d;
    logic [7:0]   err_count_q, err_count_d;
    logic [7:0]   drain_cnt_q, drain_cnt_d;
    logic         viol_valid_q, viol_valid_d;
    logic [15:0]  viol_opcode_q, viol_opcode_d;

    logic         checking;
    logic         op_enabled;
    logic         violation;
    logic [7:0]   err_inc;

    // NOTE: every variable below gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        inst_en_d     = inst_en_q;
        ext_en_d      = ext_en_q;
        err_count_d   = err_count_q;
        drain_cnt_d   = drain_cnt_q;
        viol_opcode_d = viol_opcode_q;

        // A reconfigure request in ARMED wins over a same-cycle check: the
        // tables are being cleared, so the lookup would be meaningless.
        checking   = (state_q == S_DRAIN) ||
                     (state_q == S_ARMED && !bus.cfg_start);
        op_enabled = (bus.opcode_1 != 8'hff) ? inst_en_q[bus.opcode_1]
                                             : ext_en_q[bus.opcode_2];
        violation  = checking && bus.valid_op && !op_enabled;
        err_inc    = (err_count_q == 8'hff) ? err_count_q : err_count_q + 8'd1;

        viol_valid_d = violation;
        if (violation) begin
            viol_opcode_d = (bus.opcode_1 == 8'hff) ? {8'hff, bus.opcode_2}
                                                    : {8'h00, bus.opcode_1};
            err_count_d   = err_inc;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    inst_en_d   = '0;
                    ext_en_d    = '0;
                    err_count_d = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                // The write lands even when cfg_done arrives in the same cycle.
                if (bus.cfg_valid) begin
                    if (bus.cfg_addr[5]) begin
                        ext_en_d[{bus.cfg_addr[4:0], 3'b000} +: 8] = bus.cfg_data;
                    end else begin
                        inst_en_d[{bus.cfg_addr[4:0], 3'b000} +: 8] = bus.cfg_data;
                    end
                end
                if (bus.cfg_done) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.cfg_start) begin
                    inst_en_d   = '0;
                    ext_en_d    = '0;
                    err_count_d = '0;
                    state_d     = S_LOAD;
                end else if (violation && err_inc >= ERR_LIMIT) begin
                    if (DRAIN_LEN == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_LEN;
                    end
                end
            end
            S_DRAIN: begin
                // Violations here are still reported but never reload the counter.
                drain_cnt_d = drain_cnt_q - 8'd1;
                if (drain_cnt_q == 8'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Sticky until reset.
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the enable tables live in flops and are cleared by the async
    // reset, because an all-zero table after reset is part of this block's
    // behaviour (a RAM-backed table could not offer that).
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= S_IDLE;
            inst_en_q     <= '0;
            ext_en_q      <= '0;
            err_count_q   <= '0;
            drain_cnt_q   <= '0;
            viol_valid_q  <= 1'b0;
            viol_opcode_q <= '0;
        end else begin
            state_q       <= state_d;
            inst_en_q     <= inst_en_d;
            ext_en_q      <= ext_en_d;
            err_count_q   <= err_count_d;
            drain_cnt_q   <= drain_cnt_d;
            viol_valid_q  <= viol_valid_d;
            viol_opcode_q <= viol_opcode_d;
        end
    end

    // Status outputs decode registered state only; no input reaches them
    // combinationally.
    assign bus.cfg_ready   = (state_q == S_LOAD);
    assign bus.armed       = (state_q == S_ARMED) || (state_q == S_DRAIN);
    assign bus.endsim      = (state_q == S_DONE);
    assign bus.viol_valid  = viol_valid_q;
    assign bus.viol_opcode = viol_opcode_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: doc/instr_enable_ctl.md
# instr_enable_ctl

Simulation-environment controller that owns the opcode enable tables used for cosim instruction checking. A testbench host loads the primary and 0xff-extended enable bitmaps over a byte-wide ready/valid port, then arms the checker. Once armed, the block checks every retired opcode from the core's trace, counts and reports violations, and sequences end-of-simulation through a drain window so trace and log output can flush before `endsim`.

## Interface
- `DRAIN_CYCLES`, default 4: cycles between the terminating violation and `endsim` (0..255).
- `MAX_ERRORS`, default 1: violation count that starts shutdown (1..255).

- `clk`  in  1  sole clock, rising edge.
- `reset_l`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  pulse; clear both tables and enter LOAD.
- `cfg_valid`  in  1  table write request.
- `cfg_ready`  out  1  write accepted when `cfg_valid` and `cfg_ready` are both high.
- `cfg_addr`  in  6  byte index: 0-31 selects primary, 32-63 selects extended.
- `cfg_data`  in  8  bit i enables opcode 8*(addr mod 32)+i.
- `cfg_done`  in  1  pulse; finish load and arm the checker.
- `valid_op`  in  1  a retired opcode is present this cycle.
- `opcode_1`  in  8  first opcode byte.
- `opcode_2`  in  8  second byte; used only when `opcode_1` is 8'hff.
- `armed`  out  1  high in ARMED and DRAIN.
- `viol_valid`  out  1  one-cycle pulse per violation.
- `viol_opcode`  out  16  {8'h00,opcode_1}, or {8'hff,opcode_2} for extended opcodes; holds its value until the next violation.
- `err_count`  out  8  violation count, saturates at 255.
- `endsim`  out  1  sticky abort request.

## Operation
- States: IDLE (reset state), LOAD, ARMED, DRAIN, DONE.
- IDLE, and `cfg_start`: both 256-bit tables clear, `err_count` clears, next state is LOAD. `cfg_start` is also accepted in ARMED to reconfigure. It is ignored in LOAD, DRAIN and DONE.
- LOAD: `cfg_ready` is 1. Each accepted write overwrites one table byte. Any other state has `cfg_ready` at 0 and writes are dropped. `cfg_done` moves the state to ARMED. When `cfg_valid` and `cfg_done` arrive in the same cycle, the write lands first and the state then becomes ARMED.
- ARMED/DRAIN check: on `valid_op`, the block looks up `inst_en[opcode_1]` if `opcode_1` is not 8'hff, otherwise `ext_en[opcode_2]`. A zero bit is a violation. `valid_op` is ignored in IDLE, LOAD and DONE.
- On a violation:
  - `viol_valid` pulses.
  - `viol_opcode` updates.
  - `err_count` increments, saturating.
- In ARMED, when the updated count is at or above `MAX_ERRORS`:
  - with `DRAIN_CYCLES`=0, the state goes to DONE;
  - otherwise the state goes to DRAIN with the drain counter loaded to `DRAIN_CYCLES`.
- DRAIN: the counter decrements every cycle. Violations are still checked and reported in DRAIN, but do not reload the counter. When the counter reaches 1, the next state is DONE.
- DONE: `endsim` is 1 and stays 1 until reset. The only exit is reset.
- Reset mid-operation, at any state: all state is lost and the block returns to IDLE with the tables cleared.

## Timing
- Reset values:
  - `cfg_ready`, `armed`, `viol_valid`, `endsim` = 0.
  - `viol_opcode` = 16'h0000.
  - `err_count` = 0.
  - Both tables are all-zero.
- All outputs are registered; there are no combinational input-to-output paths.
- `cfg_start` sampled at edge t: LOAD from t+1, so `cfg_ready` is high from t+1.
- A table write accepted at edge t is visible to checks sampled at t+1 onward.
- `cfg_done` at edge t: `armed` is high from t+1. A `valid_op` at t itself is not checked.
- Violation sampled at edge k: `viol_valid`, `viol_opcode` and `err_count` are valid in cycle k+1.
- Terminating violation at edge k: DRAIN occupies cycles k+1..k+D and `endsim` rises at k+D+1, where D=`DRAIN_CYCLES`. With D=0, `endsim` rises at k+1.
- Throughput: one check per cycle with no stalls.

## Test plan
- Reset, then `cfg_start`, write addr 0 = 8'h01, `cfg_done`, then `valid_op` with `opcode_1`=8'h00 -> no `viol_valid`, `err_count`=0, `endsim`=0.
- Same configuration, `valid_op` with `opcode_1`=8'h05 at edge k (D=4, MAX_ERRORS=1):
  - -> `viol_valid` at k+1 with `viol_opcode`=16'h0005;
  - -> `armed` high during k+1..k+4;
  - -> `endsim`=1 from k+5 onward.
- Extended path: write addr 33 = 8'h04, then arm:
  - `opcode_1`=ff with `opcode_2`=8'h0a -> no violation;
  - `opcode_1`=ff with `opcode_2`=8'h0b -> violation with `viol_opcode`=16'hff0b.
- MAX_ERRORS=3, violations on three consecutive cycles -> `err_count` reads 1, 2, 3, and DRAIN is entered only after the third; a further violation during DRAIN gives `err_count`=4 and `endsim` timing unchanged.
- `cfg_valid` and `cfg_done` in the same cycle with addr 2 = 8'hff -> opcodes 0x10-0x17 pass immediately after arming; a write issued in ARMED sees `cfg_ready`=0 and the table is unchanged.
- Assert `reset_l` low asynchronously in DRAIN, mid-clock -> all outputs read 0 at once, `endsim` never rises, and a post-reset check reports violations for every opcode because the tables are cleared.
